// File: rtl/shift_issue.sv
// Issue stage for the SLL/SRL/SRA shifters: decodes R-type shifts into A/B/op/rd
// and hands them downstream through a valid/ready output register backed by one skid entry.
module shift_issue #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rt_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_A,
  output logic [N-1:0] out_B,
  output logic [1:0]   out_op,
  output logic [4:0]   out_rd,
  output logic         illegal
);

  // Entry layout: {A, B, op, rd}
  localparam int EW = 2*N + 7;

  logic          w_legal;
  logic          w_var;
  logic [1:0]    w_op;
  logic [4:0]    w_amt;
  logic [EW-1:0] w_new;
  logic          w_accept;
  logic          w_acc_legal;
  logic          w_drain;
  logic          w_or_ld_new;
  logic          w_or_ld_sk;
  logic          w_sk_ld;
  logic          w_or_vld_nxt;
  logic          w_sk_vld_nxt;
  logic          w_unused;

  logic [EW-1:0] r_or;
  logic [EW-1:0] r_sk;
  logic          r_or_vld;
  logic          r_sk_vld;
  logic          r_in_ready;
  logic          r_illegal;

  always_comb begin
    w_legal = 1'b0;
    w_var   = 1'b0;
    w_op    = 2'b00;
    if (instr[31:26] == 6'd0) begin
      case (instr[5:0])
        6'h00: w_legal = 1'b1;
        6'h02: begin w_legal = 1'b1; w_op = 2'b01; end
        6'h03: begin w_legal = 1'b1; w_op = 2'b10; end
        6'h04: begin w_legal = 1'b1; w_var = 1'b1; end
        6'h06: begin w_legal = 1'b1; w_var = 1'b1; w_op = 2'b01; end
        6'h07: begin w_legal = 1'b1; w_var = 1'b1; w_op = 2'b10; end
        default: ;
      endcase
    end
  end

  assign w_amt       = w_var ? rs_data[4:0] : instr[10:6];
  assign w_new       = {rt_data, {{(N-5){1'b0}}, w_amt}, w_op, instr[15:11]};
  assign w_accept    = in_valid & r_in_ready & ~flush;
  assign w_acc_legal = w_accept & w_legal;
  assign w_drain     = r_or_vld & out_ready;
  assign w_unused    = ^{instr[25:16], rs_data[N-1:5]};

  // SK only ever holds an entry while OR is full, so OR-empty implies SK-empty.
  always_comb begin
    w_or_ld_new  = 1'b0;
    w_or_ld_sk   = 1'b0;
    w_sk_ld      = 1'b0;
    w_or_vld_nxt = r_or_vld;
    w_sk_vld_nxt = r_sk_vld;
    if (w_acc_legal) begin
      if (!r_or_vld || (w_drain && !r_sk_vld)) begin
        w_or_ld_new  = 1'b1;
        w_or_vld_nxt = 1'b1;
      end else if (w_drain) begin
        w_or_ld_sk = 1'b1;
        w_sk_ld    = 1'b1;
      end else begin
        w_sk_ld      = 1'b1;
        w_sk_vld_nxt = 1'b1;
      end
    end else if (w_drain) begin
      if (r_sk_vld) begin
        w_or_ld_sk   = 1'b1;
        w_sk_vld_nxt = 1'b0;
      end else begin
        w_or_vld_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_or_vld   <= 1'b0;
      r_sk_vld   <= 1'b0;
      r_in_ready <= 1'b1;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_or_vld   <= 1'b0;
      r_sk_vld   <= 1'b0;
      r_in_ready <= 1'b1;
      r_illegal  <= 1'b0;
    end else begin
      r_or_vld   <= w_or_vld_nxt;
      r_sk_vld   <= w_sk_vld_nxt;
      r_in_ready <= ~w_sk_vld_nxt;
      r_illegal  <= w_accept & ~w_legal;
    end
  end

  // OR data is cleared on reset so the outputs read zero; SK data needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_or <= '0;
    end else if (!flush) begin
      if (w_or_ld_new)
        r_or <= w_new;
      else if (w_or_ld_sk)
        r_or <= r_sk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_sk_ld)
      r_sk <= w_new;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_or_vld;
  assign out_A     = r_or[EW-1 -: N];
  assign out_B     = r_or[N+6 -: N];
  assign out_op    = r_or[6:5];
  assign out_rd    = r_or[4:0];
  assign illegal   = r_illegal;

endmodule

// File: doc/shift_issue.md
# shift_issue

Registered issue stage that sits directly upstream of the combinational shifters (SLL/SRL/SRA) in the execute path. It decodes MIPS R-type shift instructions, forms the shifter operands A (value) and B (zero-extended 5-bit shift amount), and presents them through a valid/ready handshake. A 2-entry skid buffer decouples decode from execute backpressure. Non-shift instructions are rejected with a status pulse.

## Interface
- `N`, default 32: datapath width. Must be ≥ 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous; discards all buffered entries.
- `in_valid` in 1: `instr`/`rs_data`/`rt_data` are valid.
- `in_ready` out 1: stage can accept this cycle. Registered; equals NOT skid-full.
- `instr` in 32: MIPS instruction word.
- `rs_data` in N: register rs value.
- `rt_data` in N: register rt value.
- `out_valid` out 1: `out_*` hold a decoded shift.
- `out_ready` in 1: downstream consumes when high with `out_valid`.
- `out_A` out N: value to shift (rt).
- `out_B` out N: shift amount, bits [N-1:5] always 0.
- `out_op` out 2: 00 SLL, 01 SRL, 10 SRA. 11 is never produced.
- `out_rd` out 5: destination register, instr[15:11].
- `illegal` out 1: one-cycle pulse when an accepted instruction is not a shift.

## Operation
- Accept = `in_valid & in_ready & ~flush`.
- Legal only if opcode instr[31:26] = 0 and funct instr[5:0] is one of:
  - 0x00 sll, 0x02 srl, 0x03 sra: B = zext(instr[10:6]).
  - 0x04 sllv, 0x06 srlv, 0x07 srav: B = zext(rs_data[4:0]); rs_data[N-1:5] is ignored.
- For all legal shifts, A = rt_data and op follows the funct.
- An accepted illegal instruction is consumed and produces no entry. `illegal` is 1 on the following cycle only.
- Storage:
  - Output register OR drives `out_*`.
  - Skid register SK.
- Per-cycle update (no flush), with a legal accept:
  - OR empty, or OR draining (`out_valid & out_ready`) with SK empty: the new entry goes to OR.
  - OR draining with SK full: SK moves to OR and the new entry goes to SK.
  - OR full and not draining: the new entry goes to SK. SK cannot already be full, because `in_ready` was 0.
- Per-cycle update with no legal accept and OR draining: SK (if full) moves to OR; otherwise OR becomes empty.
- Entries leave in acceptance order. `out_*` are stable while `out_valid & ~out_ready`.
- `flush`:
  - Next cycle: OR and SK empty, `out_valid` 0, `in_ready` 1, `illegal` 0.
  - Flush overrides a simultaneous accept and a simultaneous drain; the drain still counts as consumed by downstream.
- `rst` has priority over `flush`.

## Timing
- Reset values (cycle after `rst` sampled high): `out_valid` 0, `in_ready` 1, `out_A` 0, `out_B` 0, `out_op` 00, `out_rd` 0, `illegal` 0, SK empty.
- Reset mid-operation discards both entries with no partial output.
- Latency: an instruction accepted at edge t is on `out_*` with `out_valid` = 1 after edge t, when it enters OR directly. Entering via SK adds one cycle per stalled cycle.
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- `in_ready` is registered: it falls the cycle after SK fills and rises the cycle after SK empties. There is no combinational path from `out_ready` to `in_ready`.
- `illegal` is registered and asserts for exactly 1 cycle per rejected instruction. Back-to-back rejects produce back-to-back pulses.

## Test plan
- **SRA constant:** instr = `sra $3,$2,4` (0x00021903), rt_data = 0x8000_0000, `out_ready` = 1 → next cycle `out_valid` = 1, A = 0x8000_0000, B = 4, op = 10, rd = 3.
- **SRAV masking:** instr = `srav $5,$6,$7` (0x00E62807), rs_data = 0xFFFF_FF25 → B = 0x0000_0005, op = 10, rd = 5. B[31:5] = 0 for rs_data = 0xFFFF_FFFF (B = 31).
- **Backpressure:** `out_ready` = 0; offer sll, srl, sra on consecutive cycles → first two are accepted and `in_ready` = 0 from cycle 3, so sra is held off. Raise `out_ready` → outputs sll, srl, sra in order with `out_*` stable while stalled.
- **Illegal:** instr = `add` (0x00000020), then `j` (0x08000000) → `illegal` pulses on two consecutive cycles, `out_valid` stays 0, `in_ready` stays 1.
- **Flush:** fill OR and SK under stall, assert `flush` together with `in_valid` and a legal sll → next cycle `out_valid` = 0 and `in_ready` = 1; the sll never appears.
- **Reset mid-stall:** OR and SK full, pulse `rst` for 1 cycle → all outputs at reset values. A subsequent `srl` with shamt 31 issues with B = 31 and latency 1.
